// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a sideband tag and a 2-entry output FIFO.
// Instructions are decoded on entry and stored already decoded; illegal encodings flow through.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        FmtNone  = 3'd0,
        FmtI     = 3'd1,
        FmtS     = 3'd2,
        FmtB     = 3'd3,
        FmtU     = 3'd4,
        FmtJ     = 3'd5,
        FmtShamt = 3'd6
    } fmt_e;

    logic [31:0]     imm32;
    fmt_e            dec_fmt;
    logic            dec_ill;
    logic [XLEN-1:0] dec_imm;
    logic            is_shift;

    // funct3 001 (SLL) and 101 (SRL/SRA) are the shift-immediate encodings
    assign is_shift = (in_instr[13:12] == 2'b01);

    always_comb begin
        imm32   = '0;
        dec_fmt = FmtNone;
        dec_ill = 1'b0;
        case (in_instr[6:0])
            7'b0000011, 7'b1100111: begin
                dec_fmt = FmtI;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0010011: begin
                if (is_shift) begin
                    dec_fmt = FmtShamt;
                    if (XLEN == 64) begin
                        imm32 = {26'b0, in_instr[25:20]};
                    end else begin
                        imm32   = {27'b0, in_instr[24:20]};
                        dec_ill = in_instr[25];
                    end
                end else begin
                    dec_fmt = FmtI;
                    imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            7'b0011011: begin
                if (XLEN != 64) begin
                    dec_ill = 1'b1;
                end else if (is_shift) begin
                    dec_fmt = FmtShamt;
                    imm32   = {27'b0, in_instr[24:20]};
                    dec_ill = in_instr[25];
                end else begin
                    dec_fmt = FmtI;
                    imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            7'b0100011: begin
                dec_fmt = FmtS;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FmtB;
                imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FmtU;
                imm32   = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt = FmtJ;
                imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
            end
            7'b0110011, 7'b0001111, 7'b1110011: dec_ill = 1'b0;
            7'b0111011: dec_ill = (XLEN != 64);
            default:    dec_ill = 1'b1;
        endcase
    end

    // Shift amounts have bit 31 clear, so a uniform sign extension is safe for every format
    assign dec_imm = XLEN'($signed(imm32));

    logic [XLEN-1:0]  mem_imm [2];
    logic [2:0]       mem_fmt [2];
    logic             mem_ill [2];
    logic [TAG_W-1:0] mem_tag [2];
    logic [1:0]       count_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_imm[i] <= '0;
                mem_fmt[i] <= '0;
                mem_ill[i] <= 1'b0;
                mem_tag[i] <= '0;
            end
        end else if (flush) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                mem_imm[wr_ptr_q] <= dec_imm;
                mem_fmt[wr_ptr_q] <= dec_fmt;
                mem_ill[wr_ptr_q] <= dec_ill;
                mem_tag[wr_ptr_q] <= in_tag;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Outputs read as zero whenever the FIFO is empty
    always_comb begin
        out_imm     = '0;
        out_fmt     = '0;
        out_illegal = 1'b0;
        out_tag     = '0;
        if (out_valid) begin
            out_imm     = mem_imm[rd_ptr_q];
            out_fmt     = mem_fmt[rd_ptr_q];
            out_illegal = mem_ill[rd_ptr_q];
            out_tag     = mem_tag[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: drives an RV32 and an RV64 instance with identical stimulus and
// checks both against per-width expected records through a scoreboard queue.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_tag;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32, tag32;
    logic [2:0]  fmt32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;
    logic [2:0]  fmt64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] e_imm32;
        logic [2:0]  e_fmt32;
        logic        e_ill32;
        logic [63:0] e_imm64;
        logic [2:0]  e_fmt64;
        logic        e_ill64;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [31:0] tag;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    sb_t  cur;
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;

    function automatic vec_t mk(logic [31:0] i, logic [31:0] a, logic [2:0] f, logic l,
                                logic [63:0] b, logic [2:0] g, logic m);
        vec_t r;
        r.instr = i; r.e_imm32 = a; r.e_fmt32 = f; r.e_ill32 = l;
        r.e_imm64 = b; r.e_fmt64 = g; r.e_ill64 = m;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Scoreboard: compare head at negedge, then record this cycle's push
    always @(negedge clk) begin
        if (!rst) begin
            if (flush) begin
                sb.delete();
            end else begin
                check("out_valid", {62'b0, out_valid64, out_valid32},
                      {62'b0, {2{sb.size() != 0}}});
                if (!out_valid32) begin
                    check("idle_zero", {63'b0, |{imm32, fmt32, ill32, tag32,
                                                  imm64, fmt64, ill64, tag64}}, 64'd0);
                end else if (out_ready && sb.size() != 0) begin
                    sb_t e;
                    e = sb.pop_front();
                    pops++;
                    check("imm32", {32'b0, imm32}, {32'b0, e.v.e_imm32});
                    check("fmt_ill_tag32", {28'b0, ill32, fmt32, tag32},
                          {28'b0, e.v.e_ill32, e.v.e_fmt32, e.tag});
                    check("imm64", imm64, e.v.e_imm64);
                    check("fmt_ill_tag64", {28'b0, ill64, fmt64, tag64},
                          {28'b0, e.v.e_ill64, e.v.e_fmt64, e.tag});
                end
                if (in_valid && in_ready32) sb.push_back(cur);
            end
        end
    end

    task automatic drive(input vec_t v, input logic [31:0] tag);
        cur.v    = v;
        cur.tag  = tag;
        in_instr = v.instr;
        in_tag   = tag;
        in_valid = 1'b1;
    endtask

    task automatic push_one(input vec_t v, input logic [31:0] tag);
        drive(v, tag);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready32) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("push_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        int p0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_tag = '0;

        tbl.push_back(mk(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0));
        tbl.push_back(mk(32'h01F09093, 32'h0000001F, 3'd6, 1'b0, 64'h1F, 3'd6, 1'b0));
        tbl.push_back(mk(32'h02009093, 32'h00000000, 3'd6, 1'b1, 64'h20, 3'd6, 1'b0));
        tbl.push_back(mk(32'h03F09093, 32'h0000001F, 3'd6, 1'b1, 64'h3F, 3'd6, 1'b0));
        tbl.push_back(mk(32'h4050D093, 32'h00000005, 3'd6, 1'b0, 64'h05, 3'd6, 1'b0));
        tbl.push_back(mk(32'h123450B7, 32'h12345000, 3'd4, 1'b0, 64'h12345000, 3'd4, 1'b0));
        tbl.push_back(mk(32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0));
        tbl.push_back(mk(32'hFFFFF097, 32'hFFFFF000, 3'd4, 1'b0, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0));
        tbl.push_back(mk(32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0));
        tbl.push_back(mk(32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0));
        tbl.push_back(mk(32'hFE20AE23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0));
        tbl.push_back(mk(32'h00812083, 32'h00000008, 3'd1, 1'b0, 64'h08, 3'd1, 1'b0));
        tbl.push_back(mk(32'h7FF080E7, 32'h000007FF, 3'd1, 1'b0, 64'h7FF, 3'd1, 1'b0));
        tbl.push_back(mk(32'h002081B3, 32'h0, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0));
        tbl.push_back(mk(32'h002081BB, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b0));
        tbl.push_back(mk(32'hFFF0809B, 32'h0, 3'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0));
        tbl.push_back(mk(32'h01F0909B, 32'h0, 3'd0, 1'b1, 64'h1F, 3'd6, 1'b0));
        tbl.push_back(mk(32'h0200909B, 32'h0, 3'd0, 1'b1, 64'h0, 3'd6, 1'b1));
        tbl.push_back(mk(32'h0FF0000F, 32'h0, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0));
        tbl.push_back(mk(32'h00000073, 32'h0, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0));
        tbl.push_back(mk(32'h0000007F, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_valid", {60'b0, in_ready64, in_ready32, out_valid64, out_valid32},
              64'b1100);
        check("rst_outs_zero", {63'b0, |{imm32, fmt32, ill32, tag32, imm64, fmt64, ill64, tag64}},
              64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Isolated transactions: one push, then idle so out_valid drops again
        for (int i = 0; i < tbl.size(); i++) begin
            push_one(tbl[i], 32'h100 + i);
            @(posedge clk);
            #1;
        end
        // Back-to-back stream: push and pop together at count 1
        for (int i = 0; i < tbl.size(); i++) push_one(tbl[i], 32'h180 + i);
        repeat (3) @(posedge clk);
        #1;
        check("drain_stream", 64'(sb.size()), 64'd0);

        // Backpressure: third push held off while full, head stable
        out_ready = 1'b0;
        p0 = pops;
        push_one(tbl[0], 32'h200);
        push_one(tbl[5], 32'h201);
        drive(tbl[8], 32'h202);
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", {62'b0, in_ready64, in_ready32}, 64'd0);
            check("full_head_tag", {32'b0, tag32}, 64'h200);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_one(tbl[8], 32'h202);
        repeat (4) @(posedge clk);
        #1;
        check("bp_pop_count", 64'(pops - p0), 64'd3);
        check("bp_drain", 64'(sb.size()), 64'd0);

        // Flush with two buffered and a same-cycle push
        out_ready = 1'b0;
        push_one(tbl[1], 32'h300);
        push_one(tbl[2], 32'h301);
        drive(tbl[3], 32'h302);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_state", {61'b0, in_ready32, out_valid32, out_valid64}, 64'b100);
        out_ready = 1'b1;
        p0 = pops;
        repeat (3) @(posedge clk);
        #1;
        check("flush_no_output", 64'(pops - p0), 64'd0);

        // Asynchronous reset while full
        out_ready = 1'b0;
        push_one(tbl[6], 32'h400);
        push_one(tbl[9], 32'h401);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_state", {60'b0, in_ready64, in_ready32, out_valid64, out_valid32}, 64'b1100);
        check("midrst_zero", {63'b0, |{imm32, fmt32, ill32, tag32, imm64, fmt64, ill64, tag64}},
              64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        p0 = pops;
        push_one(tbl[tbl.size() - 1], 32'h500);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_pop", 64'(pops - p0), 64'd1);
        check("final_drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
